// File: rtl/ulaw_to_fix14_stream.sv
// Streaming u-law to 14-bit two's complement decoder with frame index tagging.
// Two registered stages (field split, decode) under valid/ready flow control.
module ulaw_to_fix14_stream #(
    parameter int FRAME_LEN = 784,
    parameter int IDX_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [13:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

    // Handshake: a transfer happens on any rising edge where valid && ready.
    // Once raised, out_valid and its payload hold until out_ready is seen.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic [2:0]       s1_chord_q, s1_chord_d;
    logic [3:0]       s1_val_q, s1_val_d;
    logic             s2_valid_q, s2_valid_d;
    logic [13:0]      s2_data_q, s2_data_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic        adv1;
    logic        adv2;
    logic        out_xfer;
    logic [7:0]  code;
    logic [13:0] mag;
    logic [13:0] dec;

    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1 && !rst;
        out_xfer = s2_valid_q && out_ready;
    end

    // Magnitude tops out at 8031, so 14 bits hold every intermediate value.
    always_comb begin
        code = ~in_data;
        mag  = ((14'({s1_val_q, 1'b0}) + 14'd33) << s1_chord_q) - 14'd33;
        dec  = s1_sign_q ? (14'd0 - mag) : mag;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_chord_d = s1_chord_q;
        s1_val_d   = s1_val_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        idx_d      = idx_q;

        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d  = code[7];
                s1_chord_d = code[6:4];
                s1_val_d   = code[3:0];
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = dec;
            end
        end

        if (out_xfer) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_chord_q <= 3'd0;
            s1_val_q   <= 4'd0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= 14'd0;
            idx_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_chord_q <= s1_chord_d;
            s1_val_q   <= s1_val_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        out_valid = s2_valid_q;
        out_data  = s2_data_q;
        out_idx   = idx_q;
        out_last  = s2_valid_q && (idx_q == LAST_IDX);
    end

endmodule
